// File: rtl/mcp3201_emu.sv
// SPI responder that emulates an MCP3201 12-bit ADC: oversamples cs_pin_n/clk_pin in the clk domain
// and shifts a captured code out on miso_pin in the MCP3201 frame format.
module mcp3201_emu #(
    parameter int SYNC_STAGES = 2,
    parameter bit TAIL_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sample_data,
    input  logic        cs_pin_n,
    input  logic        clk_pin,
    output logic        miso_pin,
    output logic        miso_oe,
    output logic [11:0] captured,
    output logic        frame_done,
    output logic        frame_abort
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_MSB,
        ST_TAIL,
        ST_ZERO
    } state_e;

    // Sync chains reset to 0 so a CS held low across reset never looks like a fresh falling edge.
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic                   cs_prev_q;
    logic                   sck_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q  <= '0;
            sck_sync_q <= '0;
            cs_prev_q  <= 1'b0;
            sck_prev_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_pin_n};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], clk_pin};
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    logic cs_s;
    logic sck_s;
    logic cs_fall;
    logic cs_rise;
    logic sck_rise;
    logic sck_fall;

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;

    // A fall only counts once a rise has been seen since CS went low, so a CPOL 1 master's first fall is skipped.
    logic       seen_rise_q, seen_rise_d;
    logic [4:0] fall_cnt_q, fall_cnt_d;
    logic       armed_q, armed_d;
    logic       qfall;

    assign qfall = sck_fall & ~cs_s & seen_rise_q;

    always_comb begin
        seen_rise_d = seen_rise_q;
        if (cs_fall || qfall) begin
            seen_rise_d = 1'b0;
        end else if (sck_rise && !cs_s) begin
            seen_rise_d = 1'b1;
        end
    end

    always_comb begin
        fall_cnt_d = fall_cnt_q;
        if (cs_fall) begin
            fall_cnt_d = 5'd0;
        end else if (qfall && (fall_cnt_q != 5'd31)) begin
            fall_cnt_d = fall_cnt_q + 5'd1;
        end
    end

    always_comb begin
        armed_d = armed_q;
        if (cs_fall) begin
            armed_d = 1'b0;
        end else if (cs_s) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_rise_q <= 1'b0;
            fall_cnt_q  <= 5'd0;
            armed_q     <= 1'b0;
        end else begin
            seen_rise_q <= seen_rise_d;
            fall_cnt_q  <= fall_cnt_d;
            armed_q     <= armed_d;
        end
    end

    state_e      state_q, state_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic [11:0] captured_q, captured_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic [4:0]  fall_num;
    logic [3:0]  msb_idx;
    logic [3:0]  tail_idx;

    // Number of the qualified fall being processed this cycle.
    assign fall_num = fall_cnt_q + 5'd1;
    assign msb_idx  = 4'(5'd14 - fall_num);
    assign tail_idx = 4'(fall_num - 5'd14);

    always_comb begin
        state_d    = state_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        captured_d = captured_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        if (cs_rise && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
            if (fall_cnt_q >= 5'd14) begin
                done_d = 1'b1;
            end else begin
                abort_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    oe_d   = 1'b0;
                    if (cs_fall && armed_q) begin
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (qfall && (fall_num == 5'd2)) begin
                        captured_d = sample_data;
                        oe_d       = 1'b1;
                        miso_d     = 1'b0;
                        state_d    = ST_MSB;
                    end
                end
                ST_MSB: begin
                    if (qfall) begin
                        miso_d = captured_q[msb_idx];
                        if (fall_num == 5'd14) begin
                            state_d = TAIL_EN ? ST_TAIL : ST_ZERO;
                        end
                    end
                end
                ST_TAIL: begin
                    if (qfall) begin
                        miso_d = captured_q[tail_idx];
                        if (fall_num == 5'd25) begin
                            state_d = ST_ZERO;
                        end
                    end
                end
                ST_ZERO: begin
                    if (qfall) begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            captured_q <= 12'd0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            captured_q <= captured_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign miso_pin    = miso_q;
    assign miso_oe     = oe_q;
    assign captured    = captured_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: doc/mcp3201_emu.md
# mcp3201_emu

Synthesizable SPI responder that emulates an MCP3201 12-bit ADC. It lets the sampler's SPI master front-end run in loopback self-test and hardware-in-the-loop benches without real converters. The block oversamples the incoming cs_n/sclk pins in the clk domain and drives a host-supplied 12-bit code onto miso in the MCP3201 frame format: null bit, MSB-first word, LSB-first tail, then zeros. It reports each completed or aborted frame to the host logic.

## Interface
- SYNC_STAGES, 2: synchronizer depth for cs_pin_n and clk_pin (legal 2..3).
- TAIL_EN, 1: 1 = emit the LSB-first tail after B0; 0 = emit zeros after B0.
- clk  in  1  system clock; sole clock of the block.
- rst  in  1  reset, asynchronous, active-high.
- sample_data  in  12  code to be converted; captured once per frame.
- cs_pin_n  in  1  SPI chip select from master, active-low, asynchronous to clk.
- clk_pin  in  1  SPI clock from master, asynchronous to clk; CPOL 0 or 1.
- miso_pin  out  1  serial data to master.
- miso_oe  out  1  output enable for the miso pad; 0 = high-Z.
- captured  out  12  code latched for the current or last frame.
- frame_done  out  1  1-cycle pulse: CS released after a complete frame.
- frame_abort  out  1  1-cycle pulse: CS released before a complete frame.

## Operation
- cs_pin_n and clk_pin each pass through a SYNC_STAGES flop chain. Edge detection runs on the synchronized copies: cs_fall, cs_rise, sck_rise, sck_fall.
- Qualified falling edge: an sck_fall while CS is low, preceded by an sck_rise since CS went low or since the last qualified fall. This makes CPOL 1 (clock idles high) work unchanged, because the initial fall is ignored.
- fall_cnt is 5 bits. It clears on cs_fall, increments on each qualified fall, and saturates at 31.
- The `armed` flag is set whenever synchronized CS is seen high and cleared on cs_fall. A cs_fall with armed=0 is ignored, e.g. CS already low when rst deasserts. The block then stays in IDLE until CS returns high.
- States and transitions:
  - IDLE: miso_oe=0, miso_pin=0. On armed cs_fall, go to SAMPLE.
  - SAMPLE: miso_oe=0. On qualified fall 2, capture sample_data into captured, set miso_oe=1, drive the null bit (0), go to MSB.
  - MSB: qualified falls 3..14 drive captured[11]..captured[0]. After fall 14, go to TAIL if TAIL_EN=1, otherwise to ZERO.
  - TAIL: qualified falls 15..25 drive captured[1]..captured[11]; B0 is not repeated. After fall 25, go to ZERO.
  - ZERO: drive 0 on every further fall.
- cs_rise in any non-IDLE state: go to IDLE, miso_oe=0, miso_pin=0.
  - fall_cnt ≥ 14 pulses frame_done.
  - Otherwise frame_abort pulses, including a CS pulse with no clocks.
- captured holds its value until the next fall-2 capture; no other event changes it.
- sample_data may change at any time; only its value at the fall-2 capture cycle matters.
- rst mid-frame: all state returns to reset values immediately, with no pulse. Recovery is through the armed rule.

## Timing
- Reset values: miso_pin=0, miso_oe=0, captured=0, frame_done=0, frame_abort=0, state IDLE, fall_cnt=0, armed=0.
- Pin-to-output latency is SYNC_STAGES+1 clk cycles, measured from a clk_pin fall or cs_pin_n edge to the miso_pin/miso_oe update. All outputs are registered.
- Master requirement: clk_pin high and low times each ≥ SYNC_STAGES+3 clk cycles. This keeps miso stable before the master's rising-edge sample.
- Master requirement: CS setup to the first edge, and CS high time, each ≥ SYNC_STAGES+2 clk cycles. Shorter pulses have undefined behaviour.
- frame_done and frame_abort assert SYNC_STAGES+1 cycles after cs_pin_n rises, for exactly one cycle. They are never asserted together.
- Back-to-back frames: an armed cs_fall on the cycle after the return to IDLE starts a new frame normally.

## Test plan
- CPOL 0, sample_data=0xA5C, 15 clocks, then CS high: the master reads 0 then 1010_0101_1100. captured=0xA5C, one frame_done pulse, miso_oe falls to 0.
- TAIL_EN=1, sample_data=0x801, 28 clocks: 0, then 0x801 MSB-first, then captured[1..11] = 0,0,0,0,0,0,0,0,0,0,1, then 0,0. One frame_done.
- CPOL 1 (clk_pin idles high), sample_data=0xFFF, 15 clocks: the same 13-bit sequence 0 then twelve 1s. The initial fall is not counted.
- CS low for 6 clocks, then high: frame_abort pulses once, frame_done stays 0, captured holds the new code latched at fall 2.
- rst asserted at fall 7 while CS stays low, then released: outputs go to their reset values, further clocks are ignored, and the next frame after CS goes high then low works correctly with sample_data=0x123.
- Two back-to-back frames with sample_data changed from 0x3C3 to 0x0F0 between them: the master reads 0x3C3, then 0x0F0, with two frame_done pulses.
